// File: rtl/video_oam_dma.sv
// ---------------------------------------------------------------------------
// video_oam_dma
//
// Host-side bus initiator that copies one CPU page (P_count bytes) into the
// video block's sprite memory. On a $4014 strobe it halts the CPU, then
// alternates CPU-memory reads and OAMDATA register writes, one per CPU cycle.
// The video block samples the rising edge of O_ppu_wren, so O_ppu_wren drops
// in every read cycle and each byte gives exactly one edge.
//
// Ports:
//   I_clock     system clock
//   I_reset     asynchronous active-low reset
//   I_tick      CPU cycle enable, one-clock pulse per CPU cycle
//   I_start     one-clock pulse, CPU wrote $4014
//   I_page      source page (high address byte), sampled with I_start
//   O_halt      CPU RDY-low request
//   O_busy      transfer in progress; selects DMA on the video host port
//   O_done      one-clock pulse at transfer end
//   O_mem_addr  CPU memory read address
//   O_mem_rden  CPU memory read enable
//   I_mem_data  CPU memory read data, valid at the tick ending a read cycle
//   O_ppu_addr  video host register address
//   O_ppu_wren  video host write enable
//   O_ppu_data  video host write data
// ---------------------------------------------------------------------------
module video_oam_dma #(
    parameter logic [2:0] P_oam_reg = 3'd4,
    parameter int         P_count   = 256
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_tick,
    input  logic        I_start,
    input  logic [7:0]  I_page,
    output logic        O_halt,
    output logic        O_busy,
    output logic        O_done,
    output logic [15:0] O_mem_addr,
    output logic        O_mem_rden,
    input  logic [7:0]  I_mem_data,
    output logic [2:0]  O_ppu_addr,
    output logic        O_ppu_wren,
    output logic [7:0]  O_ppu_data
);

    localparam int CW = (P_count > 1) ? $clog2(P_count) : 1;
    localparam logic [CW-1:0] LAST = CW'(P_count - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t        state_q;
    logic          parity_q;   // 0 = get cycle, 1 = put cycle
    logic          pending_q;  // start seen, waiting for the first counted tick
    logic [7:0]    page_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The byte counter wraps on its own; it never carries into the page.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
    end

    function automatic logic [7:0] lo_byte(input logic [CW-1:0] c);
        logic [7:0] r;
        r        = '0;
        r[CW-1:0] = c;
        return r;
    endfunction

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q    <= S_IDLE;
            parity_q   <= 1'b0;
            pending_q  <= 1'b0;
            page_q     <= '0;
            cnt_q      <= '0;
            O_halt     <= 1'b0;
            O_busy     <= 1'b0;
            O_done     <= 1'b0;
            O_mem_addr <= '0;
            O_mem_rden <= 1'b0;
            O_ppu_addr <= P_oam_reg;
            O_ppu_wren <= 1'b0;
            O_ppu_data <= '0;
        end else begin
            O_done <= 1'b0;
            if (I_tick) begin
                parity_q <= ~parity_q;
            end

            case (state_q)
                S_IDLE: begin
                    // A start has priority over a tick in the same clock, so
                    // that tick is never counted toward the transfer.
                    if (I_start) begin
                        page_q    <= I_page;
                        cnt_q     <= '0;
                        pending_q <= 1'b1;
                    end else if (pending_q && I_tick) begin
                        pending_q <= 1'b0;
                        state_q   <= S_HALT;
                        O_halt    <= 1'b1;
                        O_busy    <= 1'b1;
                    end
                end

                S_HALT: begin
                    if (I_tick) begin
                        // parity_q is the HALT cycle's parity; the next cycle
                        // is a put cycle when it is 0, and reads must land on
                        // get cycles, so insert one alignment cycle.
                        if (!parity_q) begin
                            state_q <= S_ALIGN;
                        end else begin
                            state_q    <= S_READ;
                            O_mem_rden <= 1'b1;
                            O_mem_addr <= {page_q, lo_byte(cnt_q)};
                        end
                    end
                end

                S_ALIGN: begin
                    if (I_tick) begin
                        state_q    <= S_READ;
                        O_mem_rden <= 1'b1;
                        O_mem_addr <= {page_q, lo_byte(cnt_q)};
                    end
                end

                S_READ: begin
                    if (I_tick) begin
                        state_q    <= S_WRITE;
                        O_mem_rden <= 1'b0;
                        O_ppu_data <= I_mem_data;
                        O_ppu_wren <= 1'b1;
                    end
                end

                S_WRITE: begin
                    if (I_tick) begin
                        O_ppu_wren <= 1'b0;
                        cnt_q      <= cnt_d;
                        if (cnt_q == LAST) begin
                            state_q <= S_IDLE;
                            O_halt  <= 1'b0;
                            O_busy  <= 1'b0;
                            O_done  <= 1'b1;
                        end else begin
                            state_q    <= S_READ;
                            O_mem_rden <= 1'b1;
                            O_mem_addr <= {page_q, lo_byte(cnt_d)};
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
